// File: rtl/move_executor.sv
`default_nettype none
// ============================================================================
// Module      : move_executor
// Description : Executes one cube move on six face stepper drivers (STEP/DIR/EN).
//               Optional post-move settle dwell is enabled by MOVE_SETTLE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module move_executor #(
    parameter int STEP_HALF_PERIOD  = 500,
    parameter int STEPS_PER_QUARTER = 50,
    parameter int DIR_SETUP         = 100,
    parameter int SETTLE_CYCLES     = 10000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_move,
    input  logic [3:0] next_move,
    output logic       move_done,
    output logic       busy,
    output logic [5:0] motor_step,
    output logic [5:0] motor_dir,
    output logic [5:0] motor_en
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STEP_HI = 3'd2,
        S_STEP_LO = 3'd3,
        S_SETTLE  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam int c_TMAX_BASE = (DIR_SETUP > STEP_HALF_PERIOD) ? DIR_SETUP : STEP_HALF_PERIOD;
`ifdef MOVE_SETTLE_EN
    localparam int c_TMAX = (SETTLE_CYCLES > c_TMAX_BASE) ? SETTLE_CYCLES : c_TMAX_BASE;
`else
    localparam int c_TMAX = c_TMAX_BASE + 0 * SETTLE_CYCLES;
`endif
    localparam int c_TW = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;
    localparam int c_CW = $clog2(STEPS_PER_QUARTER + 1);

    localparam logic [c_TW-1:0] c_SETUP_LAST = c_TW'(DIR_SETUP - 1);
    localparam logic [c_TW-1:0] c_HALF_LAST  = c_TW'(STEP_HALF_PERIOD - 1);
`ifdef MOVE_SETTLE_EN
    localparam logic [c_TW-1:0] c_SETTLE_LAST = c_TW'(SETTLE_CYCLES - 1);
`endif
    localparam logic [c_CW-1:0] c_STEPS = c_CW'(STEPS_PER_QUARTER);

    state_t            r_state, w_state_next;
    logic [c_TW-1:0]   r_timer, w_timer_next;
    logic [c_CW-1:0]   r_count, w_count_next, w_count_inc;
    logic [2:0]        r_face, w_face_next;
    logic [5:0]        r_step, w_step_next;
    logic [5:0]        r_en, w_en_next;
    logic [5:0]        r_dir, w_dir_next;
    logic              r_done, w_done_next;

    logic              w_dec_valid;
    logic              w_dec_dir;
    logic [2:0]        w_dec_face;
    logic [5:0]        w_dec_onehot;
    logic [5:0]        w_face_onehot;

    // Codes 1-6 are clockwise faces 0-5, 7-12 counter-clockwise; the rest are no-ops.
    always_comb begin
        w_dec_valid = 1'b0;
        w_dec_dir   = 1'b0;
        w_dec_face  = 3'd0;
        if (next_move >= 4'd1 && next_move <= 4'd6) begin
            w_dec_valid = 1'b1;
            w_dec_dir   = 1'b1;
            w_dec_face  = 3'(next_move - 4'd1);
        end else if (next_move >= 4'd7 && next_move <= 4'd12) begin
            w_dec_valid = 1'b1;
            w_dec_dir   = 1'b0;
            w_dec_face  = 3'(next_move - 4'd7);
        end
    end

    assign w_dec_onehot  = 6'b000001 << w_dec_face;
    assign w_face_onehot = 6'b000001 << r_face;
    assign w_count_inc   = r_count + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_count_next = r_count;
        w_face_next  = r_face;
        w_step_next  = r_step;
        w_en_next    = r_en;
        w_dir_next   = r_dir;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_move) begin
                    if (w_dec_valid) begin
                        w_state_next = S_SETUP;
                        w_face_next  = w_dec_face;
                        w_en_next    = w_dec_onehot;
                        w_dir_next   = (r_dir & ~w_dec_onehot) | (w_dec_dir ? w_dec_onehot : 6'b0);
                        w_timer_next = '0;
                        w_count_next = '0;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_SETUP: begin
                if (r_timer == c_SETUP_LAST) begin
                    w_state_next = S_STEP_HI;
                    w_timer_next = '0;
                    w_step_next  = w_face_onehot;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            S_STEP_HI: begin
                if (r_timer == c_HALF_LAST) begin
                    w_state_next = S_STEP_LO;
                    w_timer_next = '0;
                    w_step_next  = 6'b0;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            S_STEP_LO: begin
                if (r_timer == c_HALF_LAST) begin
                    w_timer_next = '0;
                    w_count_next = w_count_inc;
                    if (w_count_inc == c_STEPS) begin
`ifdef MOVE_SETTLE_EN
                        w_state_next = S_SETTLE;
`else
                        w_state_next = S_DONE;
                        w_en_next    = 6'b0;
`endif
                    end else begin
                        w_state_next = S_STEP_HI;
                        w_step_next  = w_face_onehot;
                    end
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
`ifdef MOVE_SETTLE_EN
            S_SETTLE: begin
                if (r_timer == c_SETTLE_LAST) begin
                    w_state_next = S_DONE;
                    w_timer_next = '0;
                    w_en_next    = 6'b0;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
`endif
            S_DONE: begin
                // The completion pulse lands in the first IDLE cycle.
                w_state_next = S_IDLE;
                w_done_next  = 1'b1;
                w_timer_next = '0;
                w_count_next = '0;
                w_en_next    = 6'b0;
                w_step_next  = 6'b0;
            end
            default: begin
                w_state_next = S_IDLE;
                w_en_next    = 6'b0;
                w_step_next  = 6'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_count <= '0;
            r_face  <= 3'd0;
            r_step  <= 6'b0;
            r_en    <= 6'b0;
            r_dir   <= 6'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_count <= w_count_next;
            r_face  <= w_face_next;
            r_step  <= w_step_next;
            r_en    <= w_en_next;
            r_dir   <= w_dir_next;
            r_done  <= w_done_next;
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign move_done  = r_done;
    assign motor_step = r_step;
    assign motor_en   = r_en;
    assign motor_dir  = r_dir;

endmodule
`default_nettype wire
